ram2e_banked: RTL

- Parametrised successor of the Apple IIe auxiliary-slot RAM controller CPLD; runs on the 14.318 MHz master clock.
- Sequences nRAS/nCAS to the aux DRAM and routes the MD, RD and VD data buses.
- Maintains a BANK_W-bit bank register written via a $C07x soft switch. Adds register readback, a parametrised refresh divider and a synchronous reset.

---
 rtl/ram2e_banked_if.sv | 30 +++
 rtl/ram2e_banked.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram2e_banked_if.sv
// Control/strobe bundle between the Apple IIe aux slot and the banked RAM controller.
// The tri-state data buses (MD, RD, VD) are plain inout ports on the controller.
interface ram2e_banked_if #(
    parameter int unsigned RA_W = 4
);
    logic            PHI0;
    logic            PHI1;
    logic            nPRAS;
    logic            nPCAS;
    logic            nWE;
    logic            nWE80;
    logic            nEN80;
    logic            nC07X;
    logic [7:0]      MA;
    logic [RA_W-1:0] RA;
    logic            nRAS;
    logic            nCAS;
    logic            nRWE;
    logic            BANKSEL;

    modport master (
        output PHI0, PHI1, nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X, MA,
        input  RA, nRAS, nCAS, nRWE, BANKSEL
    );

    modport slave (
        input  PHI0, PHI1, nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X, MA,
        output RA, nRAS, nCAS, nRWE, BANKSEL
    );
endinterface

// File: rtl/ram2e_banked.sv
// Apple IIe aux-slot DRAM controller: RAS/CAS sequencing off C14M, bank register
// at a $C07x soft switch with readback, refresh divider and MD/RD/VD bus routing.
module ram2e_banked #(
    parameter int unsigned BANK_W     = 6,
    parameter int unsigned RA_W       = 4,
    parameter int unsigned REF_PERIOD = 13,
    parameter logic [3:0]  WR_ADDR    = 4'h3,
    parameter logic [3:0]  RD_ADDR    = 4'hB
) (
    input  logic          C14M,
    input  logic          nRST,
    ram2e_banked_if.slave bus,
    inout  wire  [7:0]    MD,
    inout  wire  [7:0]    RD,
    inout  wire  [7:0]    VD
);
    localparam int unsigned HALF_W = BANK_W / 2;
    localparam int unsigned S_W    = 4;
    localparam int unsigned REF_W  = 4;
    localparam int unsigned DATA_W = 8;

    logic [S_W-1:0]    s_q, s_d;
    logic              phi0seen_q, phi0seen_d;
    logic              phi1_q, phi1_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic [BANK_W-1:0] ba_q, ba_d;
    logic              banksel_q, banksel_d;
    logic              rdsel_q, rdsel_d;
    logic [DATA_W-1:0] vdr_q, vdr_d;
    logic              nras_q, nras_d;
    logic              ncas_q, ncas_d;
    logic [RA_W-1:0]   ra_q, ra_d;

    logic sync_c;
    logic refresh_slot_c;
    logic en80_c;
    logic cas_set_c;
    logic cas_clr_c;
    logic md_ba_oe_c;
    logic md_rd_oe_c;
    logic rd_oe_c;
    logic unused_c;

    // Sequencer: sync on the first PHI1 rise after PHI0 has been seen, then count and saturate.
    always_comb begin
        sync_c         = bus.PHI1 & ~phi1_q & phi0seen_q;
        refresh_slot_c = (ref_q == '0);
        en80_c         = ~bus.nEN80;

        phi1_d     = bus.PHI1;
        phi0seen_d = phi0seen_q | ~bus.PHI1;

        s_d = s_q;
        if (sync_c) begin
            s_d = S_W'(1);
        end else if ((s_q != '0) && (s_q != S_W'(15))) begin
            s_d = s_q + S_W'(1);
        end

        ref_d = ref_q;
        if (s_q == S_W'(1)) begin
            ref_d = (ref_q == REF_W'(REF_PERIOD - 1)) ? '0 : ref_q + REF_W'(1);
        end
    end

    // DRAM strobes and high-order address, all registered.
    always_comb begin
        nras_d = ~(sync_c
                 | (s_q == S_W'(1))
                 | (s_q == S_W'(2))
                 | ((s_q == S_W'(5)) & refresh_slot_c)
                 | ((s_q >= S_W'(7)) & (s_q <= S_W'(11))));

        cas_clr_c = (s_q == S_W'(2))
                  | (s_q == S_W'(4))
                  | ((s_q == S_W'(9))  &  bus.nWE80)
                  | ((s_q == S_W'(11)) & ~bus.nWE80);
        cas_set_c = (s_q == '0) | (s_q == S_W'(3)) | bus.nPRAS;

        ncas_d = ncas_q;
        if (cas_set_c) begin
            ncas_d = 1'b1;
        end else if (cas_clr_c) begin
            ncas_d = 1'b0;
        end

        ra_d = '0;
        if ((s_q == S_W'(6)) || (s_q == S_W'(7))) begin
            ra_d = RA_W'(ba_q[BANK_W-1:HALF_W]);
        end else if ((s_q >= S_W'(8)) && (s_q <= S_W'(11))) begin
            ra_d = RA_W'(ba_q[HALF_W-1:0]);
        end
    end

    // Soft-switch decode at S7, bank write at S13, video latch at S3.
    always_comb begin
        banksel_d = banksel_q;
        rdsel_d   = rdsel_q;
        if (s_q == S_W'(7)) begin
            banksel_d = ~bus.nC07X & (bus.MA[3:0] == WR_ADDR) & ~bus.nWE;
            rdsel_d   = ~bus.nC07X & (bus.MA[3:0] == RD_ADDR) &  bus.nWE & en80_c;
        end
        if (sync_c) begin
            banksel_d = 1'b0;
            rdsel_d   = 1'b0;
        end

        ba_d = ba_q;
        if ((s_q == S_W'(13)) && banksel_q) begin
            ba_d = MD[BANK_W-1:0];
        end

        vdr_d = vdr_q;
        if (s_q == S_W'(3)) begin
            vdr_d = RD;
        end
    end

    always_ff @(posedge C14M) begin
        if (!nRST) begin
            s_q        <= '0;
            phi0seen_q <= 1'b0;
            phi1_q     <= 1'b0;
            ref_q      <= '0;
            ba_q       <= '0;
            banksel_q  <= 1'b0;
            rdsel_q    <= 1'b0;
            vdr_q      <= '0;
            nras_q     <= 1'b1;
            ncas_q     <= 1'b1;
            ra_q       <= '0;
        end else begin
            s_q        <= s_d;
            phi0seen_q <= phi0seen_d;
            phi1_q     <= phi1_d;
            ref_q      <= ref_d;
            ba_q       <= ba_d;
            banksel_q  <= banksel_d;
            rdsel_q    <= rdsel_d;
            vdr_q      <= vdr_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            ra_q       <= ra_d;
        end
    end

    // RD is only driven when MD is an input, so the two buses never fight.
    assign md_ba_oe_c = rdsel_q & ~bus.PHI1;
    assign md_rd_oe_c = en80_c & bus.nWE & ~rdsel_q;
    assign rd_oe_c    = en80_c & ~bus.nWE & ~md_ba_oe_c;

    assign MD = md_ba_oe_c ? DATA_W'(ba_q) :
                md_rd_oe_c ? RD            : {DATA_W{1'bz}};
    assign RD = rd_oe_c    ? MD            : {DATA_W{1'bz}};
    assign VD = ~bus.PHI1  ? vdr_q         : {DATA_W{1'bz}};

    assign bus.RA      = ra_q;
    assign bus.nRAS    = nras_q;
    assign bus.nCAS    = ncas_q;
    assign bus.nRWE    = bus.nWE80;
    assign bus.BANKSEL = banksel_q;

    assign unused_c = ^{bus.PHI0, bus.nPCAS, bus.MA[7:4], MD};
endmodule
